scatter_scheduler: RTL and testbench

// - Sequences one charge-scatter pass for the gyropoint accumulator.
// - Zeroes the charge grid, then arbitrates N_REQ gyropoint producers round-robin and issues one gyropoint per cycle.
// - Waits for the accumulator pipeline to drain, then pulses done. Sits between the gyro-averaging units and the accumulator/grid BRAM.

---
 rtl/scatter_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_scatter_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/scatter_scheduler.sv
// Scatter pass sequencer: clear the grid, round-robin issue gyropoints to the accumulator (1-cycle latency), drain, pulse done.
// Backpressure: requesters stall on req_ready. Optional SCATTER_STATS_EN adds a saturating stall_cycles counter.
module scatter_scheduler #(
  parameter int N_REQ          = 4,
  parameter int ACC_LATENCY    = 6,
  parameter int GRID_WORDS     = 4096,
  parameter int CNTW           = 20,
  parameter int PWIDTH         = 16,
  parameter int GRID_ADDRWIDTH = $clog2(GRID_WORDS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CNTW-1:0]                n_gyro,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ-1:0][PWIDTH-1:0]   req_gyro_y,
  input  logic [N_REQ-1:0][PWIDTH-1:0]   req_gyro_x,
  output logic                           acc_valid,
  output logic [PWIDTH-1:0]              acc_gyro_y,
  output logic [PWIDTH-1:0]              acc_gyro_x,
  output logic                           clr_we,
  output logic [GRID_ADDRWIDTH-1:0]      clr_addr,
  output logic                           busy,
  output logic                           done
`ifdef SCATTER_STATS_EN
  ,
  output logic [CNTW-1:0]                stall_cycles
`endif
);

  localparam int RRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW  = $clog2(ACC_LATENCY + 2);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(ACC_LATENCY + 1);
  localparam logic [GRID_ADDRWIDTH-1:0] LAST_ADDR = GRID_ADDRWIDTH'(GRID_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_SCATTER, S_DRAIN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNTW-1:0]           n_gyro_q, n_gyro_d;
  logic [CNTW-1:0]           issued_q, issued_d;
  logic [RRW-1:0]            rr_q, rr_d;
  logic [DW-1:0]             drain_q, drain_d;
  logic                      clr_we_q, clr_we_d;
  logic [GRID_ADDRWIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                      acc_valid_q, acc_valid_d;
  logic [PWIDTH-1:0]         acc_y_q, acc_y_d;
  logic [PWIDTH-1:0]         acc_x_q, acc_x_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
`ifdef SCATTER_STATS_EN
  logic [CNTW-1:0]           stall_q, stall_d;
`endif

  logic                      found;
  logic [RRW-1:0]            gnt_idx;
  logic [RRW-1:0]            cand;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found     = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    req_ready = '0;
    if (state_q == S_SCATTER && issued_q < n_gyro_q) begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = RRW'((int'(rr_q) + k) % N_REQ);
        if (!found && req_valid[cand]) begin
          found   = 1'b1;
          gnt_idx = cand;
        end
      end
      if (found) req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    n_gyro_d    = n_gyro_q;
    issued_d    = issued_q;
    rr_d        = rr_q;
    drain_d     = drain_q;
    clr_we_d    = 1'b0;
    clr_addr_d  = clr_addr_q;
    acc_valid_d = 1'b0;
    acc_y_d     = acc_y_q;
    acc_x_d     = acc_x_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef SCATTER_STATS_EN
    stall_d     = stall_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_CLEAR;
          n_gyro_d   = n_gyro;
          issued_d   = '0;
          clr_we_d   = 1'b1;
          clr_addr_d = '0;
          busy_d     = 1'b1;
`ifdef SCATTER_STATS_EN
          stall_d    = '0;
`endif
        end
      end
      S_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          clr_addr_d = '0;
          if (n_gyro_q == '0) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_LOAD;
          end else begin
            state_d = S_SCATTER;
          end
        end else begin
          clr_we_d   = 1'b1;
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      S_SCATTER: begin
        if (found) begin
          rr_d        = gnt_idx;
          issued_d    = issued_q + 1'b1;
          acc_valid_d = 1'b1;
          acc_y_d     = req_gyro_y[gnt_idx];
          acc_x_d     = req_gyro_x[gnt_idx];
          if (issued_q + 1'b1 == n_gyro_q) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end
`ifdef SCATTER_STATS_EN
        else if (stall_q != '1) begin
          stall_d = stall_q + 1'b1;
        end
`endif
      end
      S_DRAIN: begin
        if (drain_q == DW'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_gyro_q    <= '0;
      issued_q    <= '0;
      rr_q        <= RRW'(N_REQ - 1);
      drain_q     <= '0;
      clr_we_q    <= 1'b0;
      clr_addr_q  <= '0;
      acc_valid_q <= 1'b0;
      acc_y_q     <= '0;
      acc_x_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SCATTER_STATS_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      n_gyro_q    <= n_gyro_d;
      issued_q    <= issued_d;
      rr_q        <= rr_d;
      drain_q     <= drain_d;
      clr_we_q    <= clr_we_d;
      clr_addr_q  <= clr_addr_d;
      acc_valid_q <= acc_valid_d;
      acc_y_q     <= acc_y_d;
      acc_x_q     <= acc_x_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SCATTER_STATS_EN
      stall_q     <= stall_d;
`endif
    end
  end

  assign clr_we     = clr_we_q;
  assign clr_addr   = clr_addr_q;
  assign acc_valid  = acc_valid_q;
  assign acc_gyro_y = acc_y_q;
  assign acc_gyro_x = acc_x_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef SCATTER_STATS_EN
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_scatter_scheduler.sv
// Randomized scoreboard bench for scatter_scheduler: driver predicts grants/payloads, monitor checks acc output and done timing.
module tb_scatter_scheduler;
  localparam int N_REQ = 4, ACC_LATENCY = 6, GRID_WORDS = 16, CNTW = 20, PWIDTH = 16, AW = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [CNTW-1:0] n_gyro = '0;
  logic [N_REQ-1:0] req_valid = '0, req_ready;
  logic [N_REQ-1:0][PWIDTH-1:0] req_gyro_y = '0, req_gyro_x = '0;
  logic acc_valid, clr_we, busy, done;
  logic [PWIDTH-1:0] acc_gyro_y, acc_gyro_x;
  logic [AW-1:0] clr_addr;
`ifdef SCATTER_STATS_EN
  logic [CNTW-1:0] stall_cycles;
`endif

  scatter_scheduler #(.N_REQ(N_REQ), .ACC_LATENCY(ACC_LATENCY), .GRID_WORDS(GRID_WORDS),
                      .CNTW(CNTW), .PWIDTH(PWIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .n_gyro(n_gyro),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_gyro_y(req_gyro_y), .req_gyro_x(req_gyro_x),
    .acc_valid(acc_valid), .acc_gyro_y(acc_gyro_y), .acc_gyro_x(acc_gyro_x),
    .clr_we(clr_we), .clr_addr(clr_addr), .busy(busy), .done(done)
`ifdef SCATTER_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [PWIDTH-1:0] y; logic [PWIDTH-1:0] x; } gp_t;
  gp_t exp_q[$];
  gp_t mon_e;
  int tests = 0, fails = 0;
  int model_rr = N_REQ - 1;
  int mcyc = 0, last_acc = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first valid requester after the previous winner.
  function automatic int pick(input logic [N_REQ-1:0] v);
    for (int k = 1; k <= N_REQ; k++) begin
      if (v[(model_rr + k) % N_REQ]) return (model_rr + k) % N_REQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    mcyc++;
    if (!rst) begin
      if (clr_we) chk("clr_acc_exclusive", acc_valid, 0);
      if (acc_valid) begin
        chk("acc_expected_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("acc_gyro_y", acc_gyro_y, mon_e.y);
          chk("acc_gyro_x", acc_gyro_x, mon_e.x);
        end
        last_acc = mcyc;
      end
      if (done) begin
        if (last_acc >= 0) chk("done_after_last_acc", mcyc - last_acc, ACC_LATENCY + 1);
        last_acc = -1;
      end
    end else begin
      last_acc = -1;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_acc_valid"}, acc_valid, 0);
    chk({tag, "_acc_y"}, acc_gyro_y, 0);
    chk({tag, "_acc_x"}, acc_gyro_x, 0);
    chk({tag, "_clr_we"}, clr_we, 0);
    chk({tag, "_clr_addr"}, clr_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef SCATTER_STATS_EN
    chk({tag, "_stall"}, stall_cycles, 0);
`endif
  endtask

  // mode: 0 all valid, 1 random, 2 only requester 2, 3 valid one cycle in three
  task automatic run_pass(input int n, input int mode, input int abort_at, input bit poke_start);
    int issued, stalls, cyc, g;
    logic [N_REQ-1:0] v;
    issued = 0; stalls = 0; cyc = 0;
    @(negedge clk); start = 1'b1; n_gyro = CNTW'(n);
    @(negedge clk); start = 1'b0;
    for (int a = 0; a < GRID_WORDS; a++) begin
      chk("clr_we", clr_we, 1);
      chk("clr_addr", clr_addr, a);
      chk("busy_clear", busy, 1);
      chk("ready_clear", req_ready, 0);
      start = poke_start && (a == 3);
      n_gyro = CNTW'($urandom);
      req_valid = '1;
      @(negedge clk);
    end
    start = 1'b0;
    chk("clr_ends", clr_we, 0);
    while (issued < n) begin
      case (mode)
        0: v = '1;
        1: v = N_REQ'($urandom);
        2: v = N_REQ'(4);
        default: v = (cyc % 3 == 2) ? '1 : '0;
      endcase
      req_valid = v;
      for (int i = 0; i < N_REQ; i++) begin
        req_gyro_y[i] = PWIDTH'($urandom);
        req_gyro_x[i] = PWIDTH'($urandom);
      end
      #1;
      g = pick(v);
      chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
      if (g >= 0) begin
        exp_q.push_back({req_gyro_y[g], req_gyro_x[g]});
        issued++;
        model_rr = g;
      end else begin
        stalls++;
      end
      cyc++;
      @(negedge clk);
      if (issued == abort_at) begin
        #2 rst = 1'b1;
        #1 chk_reset_outputs("abort");
        model_rr = N_REQ - 1;
        req_valid = '0;
        @(negedge clk); rst = 1'b0;
        chk("abort_sb_empty", exp_q.size(), 0);
        exp_q.delete();
        return;
      end
      if (cyc > 500) begin
        chk("scatter_timeout", cyc, 0);
        break;
      end
    end
    req_valid = '1;
    for (int d = 0; d <= ACC_LATENCY; d++) begin
      #1;
      chk("ready_drain", req_ready, 0);
      chk("done_early", done, 0);
      chk("busy_drain", busy, 1);
      @(negedge clk);
    end
    req_valid = '0;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("done_single", done, 0);
    chk("busy_idle", busy, 0);
    @(negedge clk);
    chk("start_at_done_ignored", busy, 0);
    chk("sb_empty", exp_q.size(), 0);
`ifdef SCATTER_STATS_EN
    chk("stall_cycles", stall_cycles, stalls);
`endif
  endtask

  initial begin
    @(negedge clk);
    chk_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;
    run_pass(0, 0, -1, 1'b0);
    run_pass(8, 0, -1, 1'b0);
    run_pass(5, 2, -1, 1'b1);
    run_pass(10, 0, 3, 1'b0);
    run_pass(6, 0, -1, 1'b0);
    run_pass(4, 3, -1, 1'b0);
    for (int r = 0; r < 6; r++) run_pass($urandom_range(1, 20), 1, -1, r[0]);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d", tests);
    $fatal(1, "watchdog");
  end
endmodule
